enc4to2_seq: RTL and testbench

- Registered priority encoder: the inverse of the team's 2-to-4 decoder.
- Captures one-hot or multi-hot request lines into a pending register.
- Presents the index of the highest-numbered pending request as a binary code with a valid/acknowledge handshake, and clears each request once it is acknowledged.
- Sits in front of dec2to4-style decode logic: request lines come in, serviced indices go out.

---
 rtl/enc4to2_seq_pkg.sv | 14 +
 rtl/enc4to2_seq_prio_enc_n.sv | 30 +++
 rtl/enc4to2_seq.sv | 76 +++++++
 tb/tb_enc4to2_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/enc4to2_seq_pkg.sv
// Shared types and defaults for the registered priority encoder.
// No logic; state encoding and default widths only.
// No handshake of its own.
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = $clog2(N_DEF);

endpackage

// File: rtl/enc4to2_seq_prio_enc_n.sv
// Combinational priority encoder: highest set bit of pend wins.
// Zero latency.
// No flow control; purely a function of pend.
module prio_enc_n #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pend,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    int cnt;

    always_comb begin
        idx = '0;
        cnt = 0;
        // Ascending scan so the last (highest) set bit overwrites idx.
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                idx = W'(k);
                cnt = cnt + 1;
            end
        end
        any   = |pend;
        multi = (cnt > 1);
    end

endmodule

// File: rtl/enc4to2_seq.sv
// Registered priority encoder: captures requests into pend, presents highest index.
// Request at edge t -> v=1 after edge t+1; one bubble cycle after each ack.
// y/multi frozen while v=1 until ack; new requests accumulate in pend meanwhile.
module enc4to2_seq
    import enc_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         e,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         v,
    output logic         multi,
    output logic [N-1:0] pend
);

    state_t       state, state_nx;
    logic [W-1:0] y_nx;
    logic         multi_nx;
    logic [N-1:0] clr;
    logic [W-1:0] p_idx;
    logic         p_any;
    logic         p_multi;

    prio_enc_n #(.N(N), .W(W)) u_prio (
        .pend  (pend),
        .idx   (p_idx),
        .any   (p_any),
        .multi (p_multi)
    );

    always_comb begin
        state_nx = state;
        y_nx     = y;
        multi_nx = multi;
        clr      = '0;
        case (state)
            IDLE: begin
                if (p_any) begin
                    y_nx     = p_idx;
                    multi_nx = p_multi;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    clr[y]   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            multi <= 1'b0;
            pend  <= '0;
        end else begin
            state <= state_nx;
            y     <= y_nx;
            multi <= multi_nx;
            // Set is OR'd after the clear so a re-asserted request survives its ack.
            pend  <= (pend & ~clr) | (e ? i : '0);
        end
    end

    assign v = (state == HOLD);

endmodule

// File: tb/tb_enc4to2_seq.sv
// Directed bench for enc4to2_seq with a cycle-level reference model and literal spot checks.
module tb_enc4to2_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i   = 4'b0000;
    logic       e   = 1'b0;
    logic       ack = 1'b0;
    logic [1:0] y;
    logic       v;
    logic       multi;
    logic [3:0] pend;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    enc4to2_seq #(.N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .e     (e),
        .ack   (ack),
        .y     (y),
        .v     (v),
        .multi (multi),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    // Reference model: pending set, presented flag, frozen code.
    logic [3:0] m_pend  = 4'b0000;
    bit         m_hold  = 1'b0;
    int         m_y     = 0;
    bit         m_multi = 1'b0;

    function automatic int top_index(input logic [3:0] s);
        for (int k = 3; k >= 0; k--)
            if (s[k]) return k;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [3:0] nxt;
        if (rst) begin
            m_pend = 4'b0000; m_hold = 1'b0; m_y = 0; m_multi = 1'b0;
        end else begin
            nxt = m_pend;
            if (m_hold && ack) begin
                nxt[m_y] = 1'b0;
                m_hold   = 1'b0;
            end else if (!m_hold && m_pend != 4'b0000) begin
                m_y     = top_index(m_pend);
                m_multi = ($countones(m_pend) > 1);
                m_hold  = 1'b1;
            end
            if (e) nxt = nxt | i;
            m_pend = nxt;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_v",     int'(v),     int'(m_hold));
            chk("model_y",     int'(y),     m_y);
            chk("model_multi", int'(multi), int'(m_multi));
            chk("model_pend",  int'(pend),  int'(m_pend));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string tag, input int ey, input int ev, input int em, input int ep);
        chk({tag, "_y"},     int'(y),     ey);
        chk({tag, "_v"},     int'(v),     ev);
        chk({tag, "_multi"}, int'(multi), em);
        chk({tag, "_pend"},  int'(pend),  ep);
    endtask

    int exp_codes[3] = '{3, 1, 0};
    int exp_multi[3] = '{1, 1, 0};

    initial begin
        int grants;
        #12;
        lit("reset", 0, 0, 0, 0);
        check_en = 1'b1;
        cyc(1);
        rst = 1'b0; e = 1'b1; i = 4'b0000;

        // Idle for five cycles
        cyc(5);
        lit("idle", 0, 0, 0, 0);

        // Single request
        i = 4'b0100;
        cyc(1); i = 4'b0000;
        lit("single_t", 0, 0, 0, 4'b0100);
        cyc(1);
        lit("single_t1", 2, 1, 0, 4'b0100);
        cyc(10);
        lit("single_hold", 2, 1, 0, 4'b0100);
        ack = 1'b1;
        cyc(1); ack = 1'b0;
        lit("single_ack", 2, 0, 0, 0);
        cyc(2);
        chk("single_after_v", int'(v), 0);

        // Multi-hot ordering
        i = 4'b1011;
        cyc(1); i = 4'b0000;
        grants = 0;
        for (int c = 0; c < 20 && grants < 3; c++) begin
            cyc(1);
            if (v) begin
                chk("order_code",  int'(y),     exp_codes[grants]);
                chk("order_multi", int'(multi), exp_multi[grants]);
                grants++;
                ack = 1'b1;
                cyc(1); ack = 1'b0;
                chk("order_bubble", int'(v), 0);
            end
        end
        chk("order_grants", grants, 3);
        chk("order_pend_empty", int'(pend), 0);

        // Frozen output and set-wins
        i = 4'b0001;
        cyc(1); i = 4'b0000;
        cyc(1);
        lit("frz_load", 0, 1, 0, 4'b0001);
        i = 4'b1000;
        cyc(1); i = 4'b0000;
        lit("frz_hold", 0, 1, 0, 4'b1001);
        cyc(2);
        lit("frz_hold2", 0, 1, 0, 4'b1001);
        ack = 1'b1; i = 4'b0001;
        cyc(1); ack = 1'b0; i = 4'b0000;
        lit("setwins", 0, 0, 0, 4'b1001);
        cyc(1);
        lit("setwins_hi", 3, 1, 1, 4'b1001);
        ack = 1'b1;
        cyc(1); ack = 1'b0;
        lit("setwins_ack", 3, 0, 1, 4'b0001);
        cyc(1);
        lit("setwins_lo", 0, 1, 0, 4'b0001);
        ack = 1'b1;
        cyc(1); ack = 1'b0;
        lit("setwins_done", 0, 0, 0, 0);

        // Enable gating and ack while idle
        e = 1'b0; i = 4'b1111;
        cyc(4);
        lit("gate", 0, 0, 0, 0);
        e = 1'b1; i = 4'b0010; ack = 1'b1;
        cyc(1); i = 4'b0000;
        lit("idle_ack", 0, 0, 0, 4'b0010);
        cyc(1); ack = 1'b0;
        lit("gate_open", 1, 1, 0, 4'b0010);
        ack = 1'b1;
        cyc(1); ack = 1'b0;
        chk("gate_clear", int'(pend), 0);

        // Async reset mid-handshake
        i = 4'b1100;
        cyc(1); i = 4'b0000;
        cyc(1);
        lit("pre_rst", 3, 1, 1, 4'b1100);
        check_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        lit("async_rst", 0, 0, 0, 0);
        check_en = 1'b1;
        cyc(1); rst = 1'b0;
        cyc(3);
        lit("post_rst", 0, 0, 0, 0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
